// File: rtl/data_bus_pkg.sv
// Shared definitions for the data bus: MMIO register map, CTRL/STAT layout
// and the default MMIO window base.
package data_bus_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned OFF_W  = 16;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;

    localparam logic [OFF_W-1:0] OFF_GPIO_OUT = 16'h0000;
    localparam logic [OFF_W-1:0] OFF_GPIO_IN  = 16'h0004;
    localparam logic [OFF_W-1:0] OFF_COUNT    = 16'h0010;
    localparam logic [OFF_W-1:0] OFF_CMP      = 16'h0014;
    localparam logic [OFF_W-1:0] OFF_CTRL     = 16'h0018;
    localparam logic [OFF_W-1:0] OFF_STAT     = 16'h001C;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_AUTO   = 1;
    localparam int unsigned CTRL_IE     = 2;
    localparam int unsigned STAT_MATCH  = 0;
    localparam int unsigned STAT_BUSERR = 1;

    localparam int unsigned CTRL_W = 3;
    localparam int unsigned STAT_W = 2;

    // Packed so that bit positions match CTRL_* / STAT_* above.
    typedef struct packed {
        logic ie;
        logic auto_clr;
        logic en;
    } ctrl_t;

    typedef struct packed {
        logic buserr;
        logic match;
    } stat_t;

    // True for every offset that has a register behind it.
    function automatic logic offset_defined(input logic [OFF_W-1:0] off);
        logic hit;
        hit = 1'b0;
        case (off)
            OFF_GPIO_OUT, OFF_GPIO_IN, OFF_COUNT,
            OFF_CMP, OFF_CTRL, OFF_STAT: hit = 1'b1;
            default:                     hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/data_bus_timer.sv
// Compare timer for the data bus: COUNT/CMP/CTRL/STAT registers and the
// registered interrupt output.
module bus_timer
    import data_bus_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [OFF_W-1:0]  offset,
    input  logic [WORD_W-1:0] wdata,
    input  logic              buserr_set,
    output logic [WORD_W-1:0] rdata,
    output logic              irq
);

    logic [WORD_W-1:0] count_q, count_d;
    logic [WORD_W-1:0] cmp_q, cmp_d;
    ctrl_t             ctrl_q, ctrl_d;
    stat_t             stat_q, stat_d;
    logic              irq_d;
    logic              match_hit;

    // Next-state: software writes override the running count; a new match
    // overrides a same-cycle clear of MATCH.
    always_comb begin
        count_d   = count_q;
        cmp_d     = cmp_q;
        ctrl_d    = ctrl_q;
        stat_d    = stat_q;
        match_hit = ctrl_q.en && (count_q == cmp_q);

        if (ctrl_q.en) begin
            if (match_hit && ctrl_q.auto_clr) begin
                count_d = '0;
            end else begin
                count_d = count_q + WORD_W'(1);
            end
        end

        if (wr) begin
            case (offset)
                OFF_COUNT: count_d = wdata;
                OFF_CMP:   cmp_d   = wdata;
                OFF_CTRL:  ctrl_d  = ctrl_t'(wdata[CTRL_W-1:0]);
                OFF_STAT:  stat_d  = stat_t'(stat_q & ~wdata[STAT_W-1:0]);
                default:   ;
            endcase
        end

        if (match_hit) begin
            stat_d.match = 1'b1;
        end
        if (buserr_set) begin
            stat_d.buserr = 1'b1;
        end

        irq_d = stat_d.match & ctrl_d.ie;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            cmp_q   <= '1;
            ctrl_q  <= '0;
            stat_q  <= '0;
            irq     <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            stat_q  <= stat_d;
            irq     <= irq_d;
        end
    end

    // Read-back; offsets outside the timer return zero.
    always_comb begin
        rdata = '0;
        case (offset)
            OFF_COUNT: rdata = count_q;
            OFF_CMP:   rdata = cmp_q;
            OFF_CTRL:  rdata = WORD_W'(ctrl_q);
            OFF_STAT:  rdata = WORD_W'(stat_q);
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_bus.sv
// Memory-mapped data bus behind the core's MEM stage: word RAM, GPIO with
// input synchronizer, and the compare timer.
module data_bus
    import data_bus_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_wr,
    output logic [31:0] data_in,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic        irq
);

    localparam int unsigned IDX_W = $clog2(RAM_WORDS);

    logic [WORD_W-1:0] mem [RAM_WORDS];
    logic [IDX_W-1:0]  ram_idx;
    logic [OFF_W-1:0]  offset;
    logic              ram_hit;
    logic              mmio_hit;
    logic              off_ok;
    logic              buserr_set;
    logic              timer_wr;
    logic [WORD_W-1:0] timer_rdata;
    logic [WORD_W-1:0] sync1;
    logic [WORD_W-1:0] sync2;
    logic              unused_low_bits;

    assign unused_low_bits = ^data_addr[1:0];

    // Address decode; byte lane bits are ignored everywhere.
    assign ram_hit    = (data_addr[31:12] == 20'd0);
    assign mmio_hit   = (data_addr[31:16] == MMIO_BASE[31:16]);
    assign ram_idx    = data_addr[2 +: IDX_W];
    assign offset     = {data_addr[OFF_W-1:2], 2'b00};
    assign off_ok     = offset_defined(offset);
    assign timer_wr   = data_wr && mmio_hit && !ram_hit;
    assign buserr_set = data_wr && !ram_hit && !(mmio_hit && off_ok);

    always_ff @(posedge clk) begin
        if (data_wr && ram_hit && !rst) begin
            mem[ram_idx] <= data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_out <= '0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            if (timer_wr && (offset == OFF_GPIO_OUT)) begin
                gpio_out <= data_out;
            end
            sync1 <= gpio_in;
            sync2 <= sync1;
        end
    end

    bus_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr         (timer_wr),
        .offset     (offset),
        .wdata      (data_out),
        .buserr_set (buserr_set),
        .rdata      (timer_rdata),
        .irq        (irq)
    );

    // Zero-latency load path into the core's MEM/WB register.
    always_comb begin
        data_in = '0;
        if (ram_hit) begin
            data_in = mem[ram_idx];
        end else if (mmio_hit) begin
            case (offset)
                OFF_GPIO_OUT: data_in = gpio_out;
                OFF_GPIO_IN:  data_in = sync2;
                default:      data_in = timer_rdata;
            endcase
        end
    end

endmodule
